// File: rtl/pp_pipeline_accel_row_packer.sv
// pp_pipeline_accel_row_packer
// Packs a one-pixel-per-beat 8-bit stream into 8-pixel (64-bit) words, row by
// row, for a frame of rows x blks blocks. The final block of each row carries
// last_w valid pixels. Block-level control uses ap_start/ap_done/ap_continue.
module pp_pipeline_accel_row_packer #(
   parameter int PPW = 8
) (
   input  logic             ap_clk,
   input  logic             ap_rst,
   input  logic             ap_start,
   output logic             ap_done,
   input  logic             ap_continue,
   output logic             ap_idle,
   output logic             ap_ready,
   input  logic [15:0]      rows,
   input  logic [12:0]      blks,
   input  logic [3:0]       last_blk_w,
   input  logic [7:0]       s_pix_tdata,
   input  logic             s_pix_tvalid,
   output logic             s_pix_tready,
   output logic [PPW*8-1:0] m_tdata,
   output logic [PPW-1:0]   m_tkeep,
   output logic             m_tlast,
   output logic             m_tuser,
   output logic             m_tvalid,
   input  logic             m_tready
);

   localparam logic [3:0] FULL_W = 4'd8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PACK = 2'd1,
      EMIT = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [15:0]        r_rows;
   logic [12:0]        r_blks;
   logic [3:0]         r_last_w;
   logic [15:0]        r_row;
   logic [12:0]        r_blk;
   logic [2:0]         r_idx;
   logic [PPW*8-1:0]   r_word;
   logic [PPW-1:0]     r_keep;
   logic               r_done_flag;

   logic [3:0]         w_last_w;
   logic               w_last_blk;
   logic               w_last_row;
   logic [3:0]         w_fill;
   logic               w_word_done;
   logic               w_accept;
   logic               w_ap_idle;
   logic               w_ap_ready;
   logic               w_tready;
   logic               w_tvalid;

   // A width of 0 or wider than a word means a full final block.
   assign w_last_w    = ((last_blk_w == 4'd0) || (last_blk_w > FULL_W)) ? FULL_W : last_blk_w;
   assign w_last_blk  = (r_blk == (r_blks - 13'd1));
   assign w_last_row  = (r_row == (r_rows - 16'd1));
   assign w_fill      = w_last_blk ? r_last_w : FULL_W;
   assign w_word_done = s_pix_tvalid && (({1'b0, r_idx} + 4'd1) == w_fill);
   assign w_accept    = ap_start && !r_done_flag;

   // Next-state and handshake decode for the frame controller.
   always_comb begin
      w_state_nxt = r_state;
      w_ap_idle   = 1'b0;
      w_ap_ready  = 1'b0;
      w_tready    = 1'b0;
      w_tvalid    = 1'b0;
      case (r_state)
         IDLE: begin
            w_ap_idle = !ap_start;
            if (w_accept) begin
               w_ap_ready = 1'b1;
               if ((rows == 16'd0) || (blks == 13'd0)) begin
                  w_state_nxt = DONE;
               end else begin
                  w_state_nxt = PACK;
               end
            end else begin
               w_state_nxt = IDLE;
            end
         end
         PACK: begin
            w_tready = 1'b1;
            if (w_word_done) begin
               w_state_nxt = EMIT;
            end else begin
               w_state_nxt = PACK;
            end
         end
         EMIT: begin
            w_tvalid = 1'b1;
            if (m_tready) begin
               if (w_last_blk && w_last_row) begin
                  w_state_nxt = DONE;
               end else begin
                  w_state_nxt = PACK;
               end
            end else begin
               w_state_nxt = EMIT;
            end
         end
         DONE: begin
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // Frame controller state register.
   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Parameter latch, row/block counters, word assembly and the done flag.
   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         r_rows      <= 16'd0;
         r_blks      <= 13'd0;
         r_last_w    <= FULL_W;
         r_row       <= 16'd0;
         r_blk       <= 13'd0;
         r_idx       <= 3'd0;
         r_word      <= '0;
         r_keep      <= '0;
         r_done_flag <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_rows   <= rows;
                  r_blks   <= blks;
                  r_last_w <= w_last_w;
                  r_row    <= 16'd0;
                  r_blk    <= 13'd0;
                  r_idx    <= 3'd0;
                  r_word   <= '0;
                  r_keep   <= '0;
               end else if (r_done_flag && ap_continue) begin
                  r_done_flag <= 1'b0;
               end else begin
                  r_done_flag <= r_done_flag;
               end
            end
            PACK: begin
               if (s_pix_tvalid) begin
                  r_word[{r_idx, 3'b000} +: 8] <= s_pix_tdata;
                  r_keep[r_idx]                <= 1'b1;
                  r_idx                        <= r_idx + 3'd1;
               end else begin
                  r_idx <= r_idx;
               end
            end
            EMIT: begin
               if (m_tready) begin
                  r_word <= '0;
                  r_keep <= '0;
                  r_idx  <= 3'd0;
                  if (w_last_blk) begin
                     r_blk <= 13'd0;
                     r_row <= r_row + 16'd1;
                  end else begin
                     r_blk <= r_blk + 13'd1;
                  end
               end else begin
                  r_idx <= r_idx;
               end
            end
            DONE: begin
               // A continue already present lets ap_done be a single-cycle pulse.
               r_done_flag <= !ap_continue;
            end
            default: begin
               r_done_flag <= 1'b0;
            end
         endcase
      end
   end

   assign ap_done      = (r_state == DONE) || r_done_flag;
   assign ap_idle      = w_ap_idle;
   assign ap_ready     = w_ap_ready;
   assign s_pix_tready = w_tready;
   assign m_tvalid     = w_tvalid;
   assign m_tdata      = r_word;
   assign m_tkeep      = r_keep;
   assign m_tlast      = w_tvalid && w_last_blk;
   assign m_tuser      = w_tvalid && (r_blk == 13'd0) && (r_row == 16'd0);

endmodule

// File: tb/tb_pp_pipeline_accel_row_packer.sv
// Directed testbench for pp_pipeline_accel_row_packer.
module tb_pp_pipeline_accel_row_packer;

   logic        ap_clk = 1'b0;
   logic        ap_rst;
   logic        ap_start;
   logic        ap_done;
   logic        ap_continue;
   logic        ap_idle;
   logic        ap_ready;
   logic [15:0] rows_i;
   logic [12:0] blks_i;
   logic [3:0]  lw_i;
   logic [7:0]  s_pix_tdata;
   logic        s_pix_tvalid;
   logic        s_pix_tready;
   logic [63:0] m_tdata;
   logic [7:0]  m_tkeep;
   logic        m_tlast;
   logic        m_tuser;
   logic        m_tvalid;
   logic        m_tready;

   int          n_checks = 0;
   int          n_err    = 0;
   int          cyc;
   int          pix_idx;
   int          pix_n;
   logic [7:0]  pix_base;
   logic        pend;
   logic        src_en;
   int          stall_left;
   logic        hold_chk;
   logic [63:0] held;

   logic [63:0] cap_data[$];
   logic [7:0]  cap_keep[$];
   logic        cap_last[$];
   logic        cap_user[$];
   int          cap_cyc[$];

   always #5 ap_clk = ~ap_clk;

   pp_pipeline_accel_row_packer #(.PPW(8)) dut (
      .ap_clk       (ap_clk),
      .ap_rst       (ap_rst),
      .ap_start     (ap_start),
      .ap_done      (ap_done),
      .ap_continue  (ap_continue),
      .ap_idle      (ap_idle),
      .ap_ready     (ap_ready),
      .rows         (rows_i),
      .blks         (blks_i),
      .last_blk_w   (lw_i),
      .s_pix_tdata  (s_pix_tdata),
      .s_pix_tvalid (s_pix_tvalid),
      .s_pix_tready (s_pix_tready),
      .m_tdata      (m_tdata),
      .m_tkeep      (m_tkeep),
      .m_tlast      (m_tlast),
      .m_tuser      (m_tuser),
      .m_tvalid     (m_tvalid),
      .m_tready     (m_tready)
   );

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check_val({tag, "_tvalid"}, 64'(m_tvalid), 64'd0);
      check_val({tag, "_tready"}, 64'(s_pix_tready), 64'd0);
      check_val({tag, "_tdata"}, m_tdata, 64'd0);
      check_val({tag, "_tkeep"}, 64'(m_tkeep), 64'd0);
      check_val({tag, "_tlast"}, 64'(m_tlast), 64'd0);
      check_val({tag, "_tuser"}, 64'(m_tuser), 64'd0);
      check_val({tag, "_done"}, 64'(ap_done), 64'd0);
      check_val({tag, "_ready"}, 64'(ap_ready), 64'd0);
      check_val({tag, "_idle"}, 64'(ap_idle), 64'd1);
   endtask

   // One clock: drive source/sink at the falling edge, record output beats.
   task automatic step();
      @(negedge ap_clk);
      cyc++;
      if (pend) pix_idx++;
      s_pix_tvalid = src_en && (pix_idx < pix_n);
      s_pix_tdata  = pix_base + 8'(pix_idx);
      pend         = s_pix_tvalid && s_pix_tready;
      if (m_tvalid && (stall_left > 0)) begin
         m_tready = 1'b0;
         if (stall_left == 5) begin
            held     = m_tdata;
            hold_chk = 1'b1;
         end else begin
            check_val("stall_data", m_tdata, held);
         end
         check_val("stall_tready", 64'(s_pix_tready), 64'd0);
         stall_left--;
      end else begin
         m_tready = 1'b1;
         if (m_tvalid) begin
            if (hold_chk) begin
               check_val("stall_release", m_tdata, held);
               hold_chk = 1'b0;
            end
            cap_data.push_back(m_tdata);
            cap_keep.push_back(m_tkeep);
            cap_last.push_back(m_tlast);
            cap_user.push_back(m_tuser);
            cap_cyc.push_back(cyc);
         end
      end
   endtask

   task automatic start_frame(input int r, input int b, input int lw, input int n, input logic [7:0] base);
      @(negedge ap_clk);
      rows_i   = 16'(r);
      blks_i   = 13'(b);
      lw_i     = 4'(lw);
      ap_start = 1'b1;
      pix_n    = n;
      pix_idx  = 0;
      pix_base = base;
      pend     = 1'b0;
      src_en   = 1'b1;
      cyc      = 0;
      cap_data.delete();
      cap_keep.delete();
      cap_last.delete();
      cap_user.delete();
      cap_cyc.delete();
      #1;
      check_val("start_ready", 64'(ap_ready), 64'd1);
   endtask

   // Run a full frame and compare every word against a reference built here.
   task automatic run_frame(input int r, input int b, input int lw, input logic [7:0] base, input bit stall);
      int          lw_s;
      int          n;
      int          k;
      int          p;
      int          t;
      int          nb;
      logic [63:0] ew;
      logic [7:0]  ek;
      lw_s = ((lw == 0) || (lw > 8)) ? 8 : lw;
      n    = r * ((b - 1) * 8 + lw_s);
      stall_left = stall ? 5 : 0;
      hold_chk   = 1'b0;
      start_frame(r, b, lw, n, base);
      step();
      ap_start = 1'b0;
      check_val("tready_t1", 64'(s_pix_tready), 64'd1);
      while (!ap_done && (cyc < 2000)) step();
      check_val("done_seen", 64'(ap_done), 64'd1);
      check_val("n_words", 64'(cap_data.size()), 64'(r * b));
      k = 0;
      p = 0;
      t = 0;
      for (int ri = 0; ri < r; ri++) begin
         for (int bi = 0; bi < b; bi++) begin
            nb = (bi == b - 1) ? lw_s : 8;
            ew = 64'd0;
            ek = 8'd0;
            for (int j = 0; j < nb; j++) begin
               ew[j*8 +: 8] = base + 8'(p);
               ek[j]        = 1'b1;
               p++;
            end
            t = t + nb + 1 + ((stall && (k == 0)) ? 5 : 0);
            if (k < cap_data.size()) begin
               check_val("word_data", cap_data[k], ew);
               check_val("word_keep", 64'(cap_keep[k]), 64'(ek));
               check_val("word_last", 64'(cap_last[k]), 64'(bi == b - 1));
               check_val("word_user", 64'(cap_user[k]), 64'((ri == 0) && (bi == 0)));
               check_val("word_time", 64'(cap_cyc[k]), 64'(t));
            end
            k++;
         end
      end
      check_val("done_time", 64'(cyc), 64'(t + 1));
      step();
      check_val("done_pulse", 64'(ap_done), 64'd0);
      check_val("pix_count", 64'(pix_idx), 64'(n));
      check_val("no_extra_beat", 64'(cap_data.size()), 64'(r * b));
   endtask

   initial begin
      ap_rst       = 1'b1;
      ap_start     = 1'b0;
      ap_continue  = 1'b1;
      rows_i       = 16'd0;
      blks_i       = 13'd0;
      lw_i         = 4'd0;
      s_pix_tvalid = 1'b0;
      s_pix_tdata  = 8'd0;
      m_tready     = 1'b1;
      pend         = 1'b0;
      src_en       = 1'b0;
      pix_idx      = 0;
      pix_n        = 0;
      pix_base     = 8'd0;
      stall_left   = 0;
      hold_chk     = 1'b0;
      held         = 64'd0;
      cyc          = 0;
      repeat (3) @(negedge ap_clk);
      check_reset_outputs("rst");
      ap_rst = 1'b0;
      @(negedge ap_clk);
      check_reset_outputs("post_rst");

      // Basic frame: 2 rows x 2 full blocks, pixels 0..31.
      run_frame(2, 2, 8, 8'h00, 1'b0);
      if (cap_data.size() == 4) begin
         check_val("basic_w0", cap_data[0], 64'h0706050403020100);
         check_val("basic_w3", cap_data[3], 64'h1F1E1D1C1B1A1918);
         check_val("basic_last1", 64'(cap_last[1]), 64'd1);
         check_val("basic_user1", 64'(cap_user[1]), 64'd0);
      end else begin
         check_val("basic_words", 64'(cap_data.size()), 64'd4);
      end

      // Partial last block of width 3, pixels 0..10.
      run_frame(1, 2, 3, 8'h00, 1'b0);
      if (cap_data.size() == 2) begin
         check_val("part_w1", cap_data[1], 64'h00000000000A0908);
         check_val("part_k1", 64'(cap_keep[1]), 64'h07);
         check_val("part_l1", 64'(cap_last[1]), 64'd1);
      end else begin
         check_val("part_words", 64'(cap_data.size()), 64'd2);
      end

      // Width 0 and 12 behave as 8; back-pressure on the first word.
      run_frame(1, 2, 0, 8'h10, 1'b1);
      run_frame(2, 1, 12, 8'h20, 1'b1);

      // Zero-size frame with held done, then a blks=0 frame with continue high.
      ap_continue = 1'b0;
      @(negedge ap_clk);
      rows_i   = 16'd0;
      blks_i   = 13'd4;
      lw_i     = 4'd8;
      ap_start = 1'b1;
      #1;
      check_val("zero_ready", 64'(ap_ready), 64'd1);
      @(negedge ap_clk);
      check_val("zero_done_t1", 64'(ap_done), 64'd1);
      check_val("zero_tvalid", 64'(m_tvalid), 64'd0);
      rows_i = 16'd3;
      blks_i = 13'd0;
      #1;
      check_val("zero_no_ack", 64'(ap_ready), 64'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge ap_clk);
         check_val("zero_done_hold", 64'(ap_done), 64'd1);
         check_val("zero_hold_no_ack", 64'(ap_ready), 64'd0);
      end
      ap_continue = 1'b1;
      #1;
      check_val("zero_cont_no_ack", 64'(ap_ready), 64'd0);
      @(negedge ap_clk);
      check_val("zero_cont_clear", 64'(ap_done), 64'd0);
      check_val("zero_second_ack", 64'(ap_ready), 64'd1);
      @(negedge ap_clk);
      ap_start = 1'b0;
      check_val("blks0_done", 64'(ap_done), 64'd1);
      check_val("blks0_tvalid", 64'(m_tvalid), 64'd0);
      @(negedge ap_clk);
      check_val("blks0_pulse", 64'(ap_done), 64'd0);

      // Reset after 5 pixels of the first word, then a fresh frame.
      stall_left = 0;
      hold_chk   = 1'b0;
      start_frame(1, 2, 8, 16, 8'h40);
      step();
      ap_start = 1'b0;
      while ((pix_idx < 5) && (cyc < 50)) step();
      check_val("rst_pix5", 64'(pix_idx), 64'd5);
      ap_rst       = 1'b1;
      src_en       = 1'b0;
      s_pix_tvalid = 1'b0;
      pend         = 1'b0;
      @(negedge ap_clk);
      check_reset_outputs("mid_rst");
      ap_rst = 1'b0;
      @(negedge ap_clk);
      check_reset_outputs("mid_rst_rel");
      check_val("mid_rst_nobeat", 64'(cap_data.size()), 64'd0);
      run_frame(1, 1, 5, 8'h80, 1'b0);
      if (cap_data.size() == 1) begin
         check_val("after_rst_w0", cap_data[0], 64'h0000008483828180);
      end else begin
         check_val("after_rst_words", 64'(cap_data.size()), 64'd1);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/pp_pipeline_accel_row_packer.md
# pp_pipeline_accel_row_packer

Packs a one-pixel-per-beat 8-bit pixel stream into 64-bit, 8-pixel output words, one row at a time, for an image of `rows` × `blks` blocks. It sits directly downstream of the last-block-width helper. It consumes that helper's 4-bit `return_r` value as `last_blk_w`, the number of valid pixels in the final block of every row. Its output feeds the pre-processing AXI4-Stream writer. Control uses the same ap_start/ap_done/ap_continue block-level handshake as its neighbours.

## Interface
- `PPW`, 8, pixels per output word (fixed; `m_tdata` = PPW×8 bits)
- `ap_clk`  in  1  clock; all logic on rising edge
- `ap_rst`  in  1  reset, synchronous, active-high
- `ap_start`  in  1  start request; parameters are sampled when it is accepted
- `ap_done`  out  1  frame complete; held until `ap_continue`
- `ap_continue`  in  1  clears the held `ap_done`
- `ap_idle`  out  1  idle indicator
- `ap_ready`  out  1  one-cycle pulse when start is accepted
- `rows`  in  16  rows per frame
- `blks`  in  13  8-pixel blocks per row, including the final partial block
- `last_blk_w`  in  4  valid pixels in the final block; 0 or >8 is treated as 8
- `s_pix_tdata`  in  8  input pixel
- `s_pix_tvalid` / `s_pix_tready`  in / out  1  input handshake
- `m_tdata`  out  64  packed word; pixel k sits in byte k (pixel 0 is the LSB byte)
- `m_tkeep`  out  8  byte-valid mask
- `m_tlast`  out  1  last word of a row
- `m_tuser`  out  1  first word of a frame
- `m_tvalid` / `m_tready`  out / in  1  output handshake

## Operation
- FSM states: IDLE, PACK, EMIT, DONE.
- IDLE:
  - `ap_idle` = !ap_start.
  - When `ap_start`=1 and the done flag is clear: latch `rows`, `blks`, and the sanitised `last_blk_w`. Pulse `ap_ready`. Clear the row counter, block counter and byte index.
  - If the latched `rows`==0 or `blks`==0, go to DONE; otherwise go to PACK.
- PACK:
  - `s_pix_tready`=1.
  - Each accepted pixel is written to byte `idx` of the word register and sets `keep[idx]`; `idx` then increments.
  - Fill target is 8, or the latched `last_w` when the block counter equals `blks`-1.
  - When the accepted pixel makes `idx+1` equal the fill target, go to EMIT.
- EMIT:
  - `m_tvalid`=1 and `s_pix_tready`=0.
  - `m_tlast`=1 on the final block of a row. `m_tuser`=1 on block 0 of row 0.
  - Unused bytes are 0 and their keep bits are 0.
  - On the `m_tready` handshake: clear the word, keep and `idx`, then advance the block counter. On the final block of a row, wrap the block counter to 0 and advance the row counter.
  - After the final block of the final row, go to DONE; otherwise go to PACK.
- DONE:
  - Set the done flag; `ap_done`=1.
  - Return to IDLE in the same cycle.
  - The done flag stays set until `ap_continue`=1. While it is set, a new `ap_start` is not accepted.
- Counters are 16-bit (rows) and 13-bit (blocks). No wrap-around is possible within the legal ranges.
- Reset mid-frame:
  - FSM goes to IDLE; counters, word, keep and the done flag clear.
  - The partial word is discarded and no output beat is produced for it.

## Timing
- Reset values: `ap_done`=0, `ap_idle`=1 when `ap_start`=0, `ap_ready`=0, `s_pix_tready`=0, `m_tvalid`=0, `m_tdata`=0, `m_tkeep`=0, `m_tlast`=0, `m_tuser`=0.
- Start accepted in cycle T:
  - `ap_ready`=1 in T.
  - `s_pix_tready`=1 from T+1.
- Output timing:
  - `m_tvalid` rises in the cycle after the pixel that completes the word is accepted.
  - After the EMIT handshake, `s_pix_tready` returns high the next cycle.
  - A full word therefore costs 8 + 1 cycles at full throughput.
- Output stability: `m_tdata`, `m_tkeep`, `m_tlast` and `m_tuser` are stable while `m_tvalid`=1 and `m_tready`=0.
- Done timing:
  - `ap_done`=1 in the cycle after the final EMIT handshake, and stays high until `ap_continue`=1 is sampled.
  - With `ap_continue` tied high, `ap_done` is a one-cycle pulse.
  - A zero-size frame raises `ap_done` in T+1.
- A simultaneous `ap_continue` and new `ap_start` in the cycle after done is legal: the done flag clears and the start is accepted in the following cycle.

## Test plan
- **Basic frame.** rows=2, blks=2, last_blk_w=8, pixels 0..31, `m_tready`=1:
  - 4 words; word0 `m_tdata`=0x0706050403020100.
  - keep=0xFF on all words; tlast on words 1 and 3; tuser on word0 only.
  - `ap_done` after word3.
- **Partial last block.** rows=1, blks=2, last_blk_w=3, pixels 0..10:
  - word1 `m_tdata`=0x00000000000A0908, keep=0x07, tlast=1.
- **Sanitised width and back-pressure.** last_blk_w=0 and last_blk_w=12, each behaving as 8. Hold `m_tready`=0 for 5 cycles during EMIT:
  - `m_tdata` is stable throughout and `s_pix_tready`=0.
  - No pixel is lost and none is duplicated.
- **Zero-size frame.** rows=0 (and separately blks=0):
  - No output beats; `ap_done`=1 at T+1.
  - With `ap_continue`=0, `ap_done` stays high and a second `ap_start` is not acknowledged until continue.
- **Reset mid-frame.** Assert `ap_rst` after 5 pixels of a word:
  - All outputs return to reset values and no partial beat is emitted.
  - A new frame afterwards produces correct words.
